// File: rtl/decoder_controller.sv
// decoder_controller: sequences the five inverse round steps (RC, RE, PE, RO, CP) per round and per file.
// Optional: define DEC_TIMEOUT_EN to add a per-step watchdog that aborts the run and raises error.
module decoder_controller #(
    parameter int NUM_FILES      = 64,
    parameter int NUM_ROUNDS     = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       RC_finish,
    input  logic       RE_finish,
    input  logic       PE_finish,
    input  logic       RO_finish,
    input  logic       CP_finish,
    output logic       RC_start,
    output logic       RE_start,
    output logic       PE_start,
    output logic       RO_start,
    output logic       CP_start,
    output logic [9:0] file_index,
    output logic [4:0] iteration,
    output logic       busy,
    output logic       done,
    output logic       error
);
    typedef enum logic [3:0] {
        IDLE, RC_S, RC_W, RE_S, RE_W, PE_S, PE_W, RO_S, RO_W, CP_S, CP_W, DONE
    } state_t;

    localparam logic [9:0] LAST_FILE  = 10'(NUM_FILES - 1);
    localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

    if (NUM_FILES < 1 || NUM_FILES > 1024) begin : g_bad_files
        $error("NUM_FILES must be 1..1024");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 32) begin : g_bad_rounds
        $error("NUM_ROUNDS must be 1..32");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..1023");
    end

    state_t     state, state_n;
    logic [9:0] file_n;
    logic [4:0] iter_n;
    logic       timeout;

`ifdef DEC_TIMEOUT_EN
    localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic       stalled;
    logic [9:0] wd_q;
    logic       err_q;

    assign stalled = (state == RC_W && !RC_finish) || (state == RE_W && !RE_finish) ||
                     (state == PE_W && !PE_finish) || (state == RO_W && !RO_finish) ||
                     (state == CP_W && !CP_finish);
    assign timeout = stalled && wd_q == WD_LAST;
    assign error   = err_q;

    // Watchdog counts stalled W cycles and is zero on every W entry; error is sticky until the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= stalled ? wd_q + 10'd1 : '0;
            err_q <= (state == IDLE && start) ? 1'b0 : (timeout ? 1'b1 : err_q);
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    // Step sequencing plus the round/file bookkeeping done when the colParity step finishes.
    always_comb begin
        state_n = state;
        file_n  = file_index;
        iter_n  = iteration;
        case (state)
            IDLE: if (start) begin
                state_n = RC_S;
                file_n  = '0;
                iter_n  = LAST_ROUND;
            end
            RC_S: state_n = RC_W;
            RC_W: state_n = RC_finish ? RE_S : RC_W;
            RE_S: state_n = RE_W;
            RE_W: state_n = RE_finish ? PE_S : RE_W;
            PE_S: state_n = PE_W;
            PE_W: state_n = PE_finish ? RO_S : PE_W;
            RO_S: state_n = RO_W;
            RO_W: state_n = RO_finish ? CP_S : RO_W;
            CP_S: state_n = CP_W;
            CP_W: if (CP_finish) begin
                state_n = RC_S;
                if (iteration != '0) iter_n = iteration - 5'd1;
                else if (file_index != LAST_FILE) begin
                    file_n = file_index + 10'd1;
                    iter_n = LAST_ROUND;
                end else state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = IDLE;
    end

    // State and datapath index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            file_index <= '0;
            iteration  <= LAST_ROUND;
        end else begin
            state      <= state_n;
            file_index <= file_n;
            iteration  <= iter_n;
        end
    end

    assign RC_start = state == RC_S;
    assign RE_start = state == RE_S;
    assign PE_start = state == PE_S;
    assign RO_start = state == RO_S;
    assign CP_start = state == CP_S;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
endmodule

// File: tb/tb_decoder_controller.sv
// tb_decoder_controller: table, directed and randomized checks of decoder_controller against a file/round/step model.
module tb_decoder_controller;
    localparam int NF = 2;
    localparam int NR = 3;
    localparam int TO = 8;

    typedef struct {
        int cyc;
        int st;
        int fi;
        int it;
        int busy;
        int done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] fin = '0;
    logic [4:0] st;
    logic [9:0] file_index;
    logic [4:0] iteration;
    logic       busy, done, error;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[16];

    always #5 clk = ~clk;

    decoder_controller #(.NUM_FILES(NF), .NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .RC_finish(fin[0]), .RE_finish(fin[1]), .PE_finish(fin[2]), .RO_finish(fin[3]), .CP_finish(fin[4]),
        .RC_start(st[0]), .RE_start(st[1]), .PE_start(st[2]), .RO_start(st[3]), .CP_start(st[4]),
        .file_index(file_index), .iteration(iteration), .busy(busy), .done(done), .error(error)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_starts"}, st, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_file"}, file_index, 0);
        chk({tag, "_iter"}, iteration, NR - 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk_idle("rst");
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // Called at the negedge of step s's start cycle; waits d extra W cycles before finishing.
    task automatic expect_step(input int s, input int f, input int r, input int d, input bit noise);
        chk("step_start", st, 1 << s);
        chk("step_file", file_index, f);
        chk("step_iter", iteration, r);
        chk("step_busy", busy, 1);
        chk("step_done", done, 0);
        chk("step_error", error, 0);
        fin = noise ? 5'($urandom) : 5'd0;
        start = noise ? 1'($urandom) : 1'b0;
        @(negedge clk);
        for (int k = 0; k < d; k++) begin
            chk("wait_starts", st, 0);
            chk("wait_file", file_index, f);
            chk("wait_iter", iteration, r);
            fin = 5'($urandom) & ~(5'd1 << s);
            start = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        chk("wait_starts", st, 0);
        fin = (noise ? 5'($urandom) : 5'd0) | (5'd1 << s);
        @(negedge clk);
        fin = '0;
        start = 1'b0;
    endtask

    task automatic run(input bit noise, input int stall_re, input bit hold_start, input bit abort_ro);
        int d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int f = 0; f < NF; f++)
            for (int r = NR - 1; r >= 0; r--)
                for (int s = 0; s < 5; s++) begin
                    if (abort_ro && f == 1 && r == NR - 1 && s == 3) begin
                        chk("abort_ro_start", st, 8);
                        chk("abort_ro_file", file_index, 1);
                        fin = '0;
                        @(negedge clk);
                        return;
                    end
                    d = noise ? int'($urandom_range(0, 3)) : 0;
                    if (stall_re > 0 && s == 1 && f == 0 && r == NR - 1) d = stall_re;
                    expect_step(s, f, r, d, noise);
                end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_starts", st, 0);
        start = hold_start;
        @(negedge clk);
        chk("end_done", done, 0);
        chk("end_busy", busy, 0);
        chk("end_file", file_index, NF - 1);
        chk("end_iter", iteration, 0);
        if (hold_start) begin
            @(negedge clk);
            start = 1'b0;
            chk("restart_rc", st, 1);
            chk("restart_file", file_index, 0);
            chk("restart_iter", iteration, NR - 1);
            chk("restart_done", done, 0);
        end
    endtask

    initial begin
        int cur;
        tbl[0]  = '{1, 1, 0, 2, 1, 0};
        tbl[1]  = '{2, 0, 0, 2, 1, 0};
        tbl[2]  = '{3, 2, 0, 2, 1, 0};
        tbl[3]  = '{5, 4, 0, 2, 1, 0};
        tbl[4]  = '{7, 8, 0, 2, 1, 0};
        tbl[5]  = '{9, 16, 0, 2, 1, 0};
        tbl[6]  = '{10, 0, 0, 2, 1, 0};
        tbl[7]  = '{11, 1, 0, 1, 1, 0};
        tbl[8]  = '{21, 1, 0, 0, 1, 0};
        tbl[9]  = '{29, 16, 0, 0, 1, 0};
        tbl[10] = '{31, 1, 1, 2, 1, 0};
        tbl[11] = '{59, 16, 1, 0, 1, 0};
        tbl[12] = '{60, 0, 1, 0, 1, 0};
        tbl[13] = '{61, 0, 1, 0, 1, 1};
        tbl[14] = '{62, 0, 1, 0, 0, 0};
        tbl[15] = '{64, 0, 1, 0, 0, 0};

        repeat (2) @(negedge clk);
        chk_idle("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");

        fin = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cur = 1;
        foreach (tbl[i]) begin
            while (cur < tbl[i].cyc) begin
                @(negedge clk);
                cur++;
            end
            chk("tbl_starts", st, tbl[i].st);
            chk("tbl_file", file_index, tbl[i].fi);
            chk("tbl_iter", iteration, tbl[i].it);
            chk("tbl_busy", busy, tbl[i].busy);
            chk("tbl_done", done, tbl[i].done);
        end
        fin = '0;

        run(1'b0, 5, 1'b0, 1'b0);
        repeat (4) run(1'b1, 0, 1'b0, 1'b0);
        run(1'b1, 0, 1'b1, 1'b0);
        do_reset();

        run(1'b1, 0, 1'b0, 1'b1);
        fin = '1;
        do_reset();
        chk("no_resume_busy", busy, 0);
        chk("no_resume_starts", st, 0);
        @(negedge clk);
        chk("no_resume_busy2", busy, 0);
        fin = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("after_rst_rc", st, 1);
        chk("after_rst_file", file_index, 0);
        chk("after_rst_iter", iteration, NR - 1);
        do_reset();

`ifdef DEC_TIMEOUT_EN
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_step(0, 0, NR - 1, 0, 1'b0);
        expect_step(1, 0, NR - 1, 0, 1'b0);
        chk("to_pe_start", st, 4);
        fin = '0;
        @(negedge clk);
        for (int k = 0; k < TO; k++) begin
            chk("to_wait_busy", busy, 1);
            chk("to_wait_error", error, 0);
            chk("to_wait_starts", st, 0);
            @(negedge clk);
        end
        chk("to_error", error, 1);
        chk("to_busy", busy, 0);
        chk("to_done", done, 0);
        @(negedge clk);
        chk("to_sticky", error, 1);
        chk("to_no_done", done, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("to_cleared", error, 0);
        chk("to_restart_rc", st, 1);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
